// File: rtl/pcs1x_rx_blocklock.sv
// 64b/66b sync-header block-lock FSM for one rx PCS lane; requests gearbox bit slips and reports lock.
// Latency: decision on the header strobed in cycle N is visible on the registered outputs in cycle N+1.
// Backpressure: none; a header is consumed on every in_sh_valid strobe and there is no ready signal.
module pcs1x_rx_blocklock #(
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 4,
  parameter int ERRCNT_W     = 16
) (
  input  logic                clkpma_rx,
  input  logic                reset_rx,
  input  logic                in_enable,
  input  logic                in_sh_valid,
  input  logic [1:0]          in_sh,
  output logic                out_block_lock,
  output logic                out_slip,
  output logic                out_lock_lost,
  output logic [ERRCNT_W-1:0] out_sh_err_cnt
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP_W = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]    invld_cnt_q, invld_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                lock_q, lock_d;
  logic                slip_q, slip_d;
  logic                lost_q, lost_d;

  // A header is good only when its two bits differ (01 or 10).
  logic                sh_ok;
  logic [SH_W-1:0]     sh_inc;
  logic [INV_W-1:0]    invld_inc;
  logic [WAIT_W-1:0]   wait_inc;
  logic                err_sat;

  assign sh_ok     = in_sh[1] ^ in_sh[0];
  assign sh_inc    = sh_cnt_q + SH_W'(1);
  assign invld_inc = invld_cnt_q + INV_W'(1);
  assign wait_inc  = wait_cnt_q + WAIT_W'(1);
  assign err_sat   = &err_cnt_q;

  // Next-state, counter and pulse decode; enable low forces the hunt state but keeps the error count.
  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_cnt_d   = err_cnt_q;
    slip_d      = 1'b0;
    lost_d      = 1'b0;

    if (!in_enable) begin
      state_d     = ST_HUNT;
      sh_cnt_d    = '0;
      invld_cnt_d = '0;
      wait_cnt_d  = '0;
    end else if (in_sh_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (!sh_ok) begin
            // Misaligned: ask for a one-bit slip and let the gearbox settle.
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            wait_cnt_d = '0;
            state_d    = ST_SLIP_W;
          end else if (sh_inc == SH_LAST) begin
            sh_cnt_d = '0;
            state_d  = ST_LOCKED;
          end else begin
            sh_cnt_d = sh_inc;
          end
        end

        ST_SLIP_W: begin
          // Headers here straddle the realignment and carry no information.
          if (wait_inc == WAIT_LAST) begin
            wait_cnt_d = '0;
            state_d    = ST_HUNT;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end

        ST_LOCKED: begin
          sh_cnt_d = sh_inc;
          if (!sh_ok) begin
            invld_cnt_d = invld_inc;
            if (!err_sat) begin
              err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end
          end
          // Too many bad headers beats a window end landing on the same strobe.
          if (!sh_ok && (invld_inc == INV_LAST)) begin
            slip_d      = 1'b1;
            lost_d      = 1'b1;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
            wait_cnt_d  = '0;
            state_d     = ST_SLIP_W;
          end else if (sh_inc == SH_LAST) begin
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end
        end

        default: begin
          state_d     = ST_HUNT;
          sh_cnt_d    = '0;
          invld_cnt_d = '0;
          wait_cnt_d  = '0;
        end
      endcase
    end

    lock_d = (state_d == ST_LOCKED);
  end

  // State, counters and registered outputs; reset also clears the sticky error count.
  always_ff @(posedge clkpma_rx) begin
    if (reset_rx) begin
      state_q     <= ST_HUNT;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_cnt_q   <= '0;
      lock_q      <= 1'b0;
      slip_q      <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_cnt_q   <= err_cnt_d;
      lock_q      <= lock_d;
      slip_q      <= slip_d;
      lost_q      <= lost_d;
    end
  end

  assign out_block_lock = lock_q;
  assign out_slip       = slip_q;
  assign out_lock_lost  = lost_q;
  assign out_sh_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pcs1x_rx_blocklock.sv
// Bench for pcs1x_rx_blocklock: full-width instance plus a 4-bit error-counter instance on shared inputs.
// Latency: every step drives one cycle and captures outputs 1 time unit after the following edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_pcs1x_rx_blocklock;

  typedef struct packed {
    logic        lock;
    logic        slip;
    logic        lost;
    logic [15:0] err16;
    logic        lock4;
    logic        slip4;
    logic        lost4;
    logic [3:0]  err4;
  } obs_t;

  logic        clkpma_rx = 1'b0;
  logic        reset_rx = 1'b1;
  logic        in_enable = 1'b0;
  logic        in_sh_valid = 1'b0;
  logic [1:0]  in_sh = 2'b00;
  logic        out_block_lock, out_slip, out_lock_lost;
  logic [15:0] out_sh_err_cnt;
  logic        lock4, slip4, lost4;
  logic [3:0]  err4;

  always #5 clkpma_rx = ~clkpma_rx;

  pcs1x_rx_blocklock dut (
    .clkpma_rx      (clkpma_rx),
    .reset_rx       (reset_rx),
    .in_enable      (in_enable),
    .in_sh_valid    (in_sh_valid),
    .in_sh          (in_sh),
    .out_block_lock (out_block_lock),
    .out_slip       (out_slip),
    .out_lock_lost  (out_lock_lost),
    .out_sh_err_cnt (out_sh_err_cnt)
  );

  pcs1x_rx_blocklock #(.ERRCNT_W(4)) dut4 (
    .clkpma_rx      (clkpma_rx),
    .reset_rx       (reset_rx),
    .in_enable      (in_enable),
    .in_sh_valid    (in_sh_valid),
    .in_sh          (in_sh),
    .out_block_lock (lock4),
    .out_slip       (slip4),
    .out_lock_lost  (lost4),
    .out_sh_err_cnt (err4)
  );

  obs_t exp_q[$];
  obs_t got_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: 0 = hunt, 1 = slip wait, 2 = locked
  int m_st = 0, m_sh = 0, m_inv = 0, m_wait = 0, m_err16 = 0, m_err4 = 0;

  function automatic logic [1:0] good_sh();
    logic [1:0] v;
    v = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic logic [1:0] bad_sh();
    logic [1:0] v;
    v = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
    return v;
  endfunction

  // Drive one cycle, push the model's expectation, capture what the DUTs produce.
  task automatic step(input logic rst, input logic en, input logic vld, input logic [1:0] sh);
    obs_t e, g;
    logic e_slip, e_lost, bad;
    reset_rx    = rst;
    in_enable   = en;
    in_sh_valid = vld;
    in_sh       = sh;
    e_slip = 1'b0;
    e_lost = 1'b0;
    bad = (sh == 2'b00) || (sh == 2'b11);
    if (rst) begin
      m_st = 0; m_sh = 0; m_inv = 0; m_wait = 0; m_err16 = 0; m_err4 = 0;
    end else if (!en) begin
      m_st = 0; m_sh = 0; m_inv = 0; m_wait = 0;
    end else if (vld) begin
      if (m_st == 0) begin
        if (bad) begin
          e_slip = 1'b1; m_sh = 0; m_wait = 0; m_st = 1;
        end else begin
          m_sh = m_sh + 1;
          if (m_sh == 64) begin m_st = 2; m_sh = 0; end
        end
      end else if (m_st == 1) begin
        m_wait = m_wait + 1;
        if (m_wait == 4) begin m_st = 0; m_wait = 0; end
      end else begin
        m_sh = m_sh + 1;
        if (bad) begin
          m_inv = m_inv + 1;
          if (m_err16 < 65535) m_err16 = m_err16 + 1;
          if (m_err4 < 15) m_err4 = m_err4 + 1;
        end
        if (m_inv == 16) begin
          e_slip = 1'b1; e_lost = 1'b1; m_st = 1; m_sh = 0; m_inv = 0; m_wait = 0;
        end else if (m_sh == 64) begin
          m_sh = 0; m_inv = 0;
        end
      end
    end
    e.lock  = (m_st == 2);
    e.slip  = e_slip;
    e.lost  = e_lost;
    e.err16 = 16'(m_err16);
    e.lock4 = (m_st == 2);
    e.slip4 = e_slip;
    e.lost4 = e_lost;
    e.err4  = 4'(m_err4);
    exp_q.push_back(e);
    @(posedge clkpma_rx);
    #1;
    g = {out_block_lock, out_slip, out_lock_lost, out_sh_err_cnt, lock4, slip4, lost4, err4};
    got_q.push_back(g);
  endtask

  task automatic test_reset();
    obs_t e, g;
    step(1'b1, 1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    vectors++;
    if ({out_block_lock, out_slip, out_lock_lost, out_sh_err_cnt, err4} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_state: got lock=%b slip=%b lost=%b err=%0d err4=%0d, want all 0",
               out_block_lock, out_slip, out_lock_lost, out_sh_err_cnt, err4);
    end
    step(1'b0, 1'b1, 1'b0, 2'b00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset_sb: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_acquire();
    obs_t e, g;
    for (int i = 1; i <= 64; i++) begin
      step(1'b0, 1'b1, 1'b1, good_sh());
      if (i == 63) begin
        vectors++;
        if (out_block_lock !== 1'b0) begin
          miscompares++;
          $display("FAIL acquire_early: got lock=%b after strobe 63, want 0", out_block_lock);
        end
      end
    end
    vectors++;
    if (out_block_lock !== 1'b1 || out_slip !== 1'b0) begin
      miscompares++;
      $display("FAIL acquire_lock: got lock=%b slip=%b after strobe 64, want lock=1 slip=0",
               out_block_lock, out_slip);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL acquire_sb: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_hunt_slip();
    obs_t e, g;
    step(1'b1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 29; i++) step(1'b0, 1'b1, 1'b1, good_sh());
    step(1'b0, 1'b1, 1'b1, 2'b11);
    vectors++;
    if (out_slip !== 1'b1 || out_block_lock !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_slip: got slip=%b lock=%b, want slip=1 lock=0", out_slip, out_block_lock);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 2'b00);
      vectors++;
      if (out_slip !== 1'b0) begin
        miscompares++;
        $display("FAIL slip_wait_ignored: got slip=%b on ignored strobe %0d, want 0", out_slip, i);
      end
    end
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, good_sh());
    vectors++;
    if (out_block_lock !== 1'b1) begin
      miscompares++;
      $display("FAIL relock: got lock=%b, want 1", out_block_lock);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL hunt_slip_sb: got %h want %h", g, e);
      end
    end
  endtask

  // Two full windows with 15 bad headers each: lock must survive both.
  task automatic test_window_errors();
    obs_t e, g;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 64; i++) begin
        step(1'b0, 1'b1, 1'b1, ((i % 4 == 1) && (i < 60)) ? bad_sh() : good_sh());
      end
      vectors++;
      if (out_block_lock !== 1'b1 || out_sh_err_cnt !== 16'(15 * (w + 1))) begin
        miscompares++;
        $display("FAIL window_errors[%0d]: got lock=%b err=%0d, want lock=1 err=%0d",
                 w, out_block_lock, out_sh_err_cnt, 15 * (w + 1));
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL window_errors_sb: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_lock_loss();
    obs_t e, g;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, bad_sh());
    vectors++;
    if ({out_block_lock, out_slip, out_lock_lost} !== 3'b011 || out_sh_err_cnt !== 16'd46) begin
      miscompares++;
      $display("FAIL lock_loss: got lock=%b slip=%b lost=%b err=%0d, want 0 1 1 err=46",
               out_block_lock, out_slip, out_lock_lost, out_sh_err_cnt);
    end
    step(1'b0, 1'b1, 1'b1, bad_sh());
    vectors++;
    if (out_slip !== 1'b0 || out_lock_lost !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: got slip=%b lost=%b one cycle later, want 0 0", out_slip, out_lock_lost);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL lock_loss_sb: got %h want %h", g, e);
      end
    end
  endtask

  // Gaps must not advance counters; enable low drops lock but keeps the error count.
  task automatic test_gaps_enable();
    obs_t e, g;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'b11);
      step(1'b0, 1'b1, 1'b1, 2'b00);
    end
    for (int i = 1; i <= 64; i++) begin
      step(1'b0, 1'b1, 1'b1, good_sh());
      for (int k = $urandom_range(0, 2); k > 0; k--) step(1'b0, 1'b1, 1'b0, 2'b00);
    end
    vectors++;
    if (out_block_lock !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_lock: got lock=%b, want 1", out_block_lock);
    end
    step(1'b0, 1'b0, 1'b1, 2'b11);
    vectors++;
    if (out_block_lock !== 1'b0 || out_sh_err_cnt !== 16'd46) begin
      miscompares++;
      $display("FAIL disable: got lock=%b err=%0d, want lock=0 err=46", out_block_lock, out_sh_err_cnt);
    end
    step(1'b0, 1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 1'b0, 2'b00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL gaps_enable_sb: got %h want %h", g, e);
      end
    end
  endtask

  // 16th bad header lands exactly on the window-end strobe.
  task automatic test_priority();
    obs_t e, g;
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, good_sh());
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, (i < 48) ? good_sh() : bad_sh());
    vectors++;
    if ({out_block_lock, out_slip, out_lock_lost} !== 3'b011) begin
      miscompares++;
      $display("FAIL loss_priority: got lock=%b slip=%b lost=%b, want 0 1 1",
               out_block_lock, out_slip, out_lock_lost);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL priority_sb: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_saturate();
    obs_t e, g;
    step(1'b1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, good_sh());
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, (i < 15) ? bad_sh() : good_sh());
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, bad_sh());
    vectors++;
    if (err4 !== 4'hF || out_sh_err_cnt !== 16'd20 || out_block_lock !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate: got err4=%h err=%0d lock=%b, want err4=f err=20 lock=1",
               err4, out_sh_err_cnt, out_block_lock);
    end
    step(1'b1, 1'b1, 1'b1, 2'b01);
    vectors++;
    if (err4 !== 4'h0 || out_sh_err_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL sat_clear: got err4=%h err=%0d, want 0 0", err4, out_sh_err_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL saturate_sb: got %h want %h", g, e);
      end
    end
  endtask

  // Random back-to-back traffic, including reset on a bad-header strobe in hunt.
  task automatic test_back_to_back();
    obs_t e, g;
    logic en, vld;
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 99) != 0);
      vld = ($urandom_range(0, 3) != 0);
      step(1'b0, en, vld, ($urandom_range(0, (i < 300) ? 199 : 15) == 0) ? bad_sh() : good_sh());
    end
    step(1'b1, 1'b1, 1'b1, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b1, 1'b1, 2'b11);
    vectors++;
    if (out_slip !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cancels_slip: got slip=%b, want 0", out_slip);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL back_to_back_sb: got %h want %h", g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_hunt_slip();
    test_window_errors();
    test_lock_loss();
    test_gaps_enable();
    test_priority();
    test_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
